// File: rtl/fp_ieee_packer_pkg.sv
// Shared FP library definitions: field widths, exception codes and the packer result record.
// The adder, packer and unpacker all import this package so field slicing stays consistent.
package fp_ieee_packer_pkg;

  localparam int unsigned SizeMantissa       = 24;
  localparam int unsigned SizeExponent       = 8;
  localparam int unsigned SizeExceptionField = 2;
  localparam int unsigned SizeCount          = 8;
  localparam int unsigned SizeFrac           = SizeMantissa - 1;
  localparam int unsigned SizeOut            = SizeMantissa + SizeExponent;
  localparam int unsigned SizeIn             = SizeOut + SizeExceptionField;

  typedef enum logic [SizeExceptionField-1:0] {
    ExcZero     = 2'd0,
    ExcNormal   = 2'd1,
    ExcInfinity = 2'd2,
    ExcNan      = 2'd3
  } exc_e;

  typedef struct packed {
    logic [SizeOut-1:0] word;
    logic               nan;
    logic               inf;
    logic               ovf;
    logic               unf;
  } pack_res_t;

endpackage

// File: rtl/fp_ieee_packer_if.sv
// Valid/ready channels into and out of the IEEE packer.
// The slave modport is the packer's view; master is the producer/consumer side.
interface fp_ieee_packer_if;
  import fp_ieee_packer_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [SizeIn-1:0]  in_number;
  logic               out_valid;
  logic               out_ready;
  logic [SizeOut-1:0] out_number;

  modport slave (
    input  in_valid, in_number, out_ready,
    output in_ready, out_valid, out_number
  );

  modport master (
    output in_valid, in_number, out_ready,
    input  in_ready, out_valid, out_number
  );

endinterface

// File: rtl/fp_pack_classify.sv
// Combinational conversion of one internal-format number to its IEEE-754 word plus event flags.
module fp_pack_classify
  import fp_ieee_packer_pkg::*;
(
  input  logic [SizeIn-1:0] number_i,
  output pack_res_t         res_o
);

  exc_e                    exc;
  logic                    sign;
  logic [SizeExponent-1:0] expo;
  logic [SizeFrac-1:0]     frac;

  assign exc  = exc_e'(number_i[SizeIn-1 -: SizeExceptionField]);
  assign sign = number_i[SizeOut-1];
  assign expo = number_i[SizeOut-2 -: SizeExponent];
  assign frac = number_i[SizeFrac-1:0];

  always_comb begin
    res_o      = '0;
    res_o.word = {sign, {(SizeOut-1){1'b0}}};
    unique case (exc)
      ExcZero: ;
      ExcNormal: begin
        if (expo == {SizeExponent{1'b1}}) begin
          res_o.word = {sign, {SizeExponent{1'b1}}, {SizeFrac{1'b0}}};
          res_o.ovf  = 1'b1;
        end else if (expo == '0) begin
          // No subnormal output: flush to signed zero.
          res_o.unf = 1'b1;
        end else begin
          res_o.word = {sign, expo, frac};
        end
      end
      ExcInfinity: begin
        res_o.word = {sign, {SizeExponent{1'b1}}, {SizeFrac{1'b0}}};
        res_o.inf  = 1'b1;
      end
      ExcNan: begin
        res_o.word = {1'b0, {SizeExponent{1'b1}}, 1'b1, {(SizeFrac-1){1'b0}}};
        res_o.nan  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fp_ieee_packer.sv
// Two-stage elastic packer: s0 holds the raw number being classified, s1 the IEEE output word.
// Sticky flags and the NaN counter update as a result moves s0 -> s1.
module fp_ieee_packer
  import fp_ieee_packer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  fp_ieee_packer_if.slave      bus,
  input  logic                 clear_flags_i,
  output logic                 flag_nan_o,
  output logic                 flag_inf_o,
  output logic                 flag_ovf_o,
  output logic                 flag_unf_o,
  output logic [SizeCount-1:0] nan_count_o
);

  logic                 s0_valid_q;
  logic [SizeIn-1:0]    s0_number_q;
  logic                 s1_valid_q;
  logic [SizeOut-1:0]   s1_number_q;
  logic                 s0_adv, s1_adv, s0_load, s1_load;
  pack_res_t            s0_res;
  logic                 flag_nan_q, flag_inf_q, flag_ovf_q, flag_unf_q;
  logic                 flag_nan_d, flag_inf_d, flag_ovf_d, flag_unf_d;
  logic [SizeCount-1:0] nan_count_q, nan_count_d;

  fp_pack_classify u_classify (
    .number_i (s0_number_q),
    .res_o    (s0_res)
  );

  assign s1_adv       = ~s1_valid_q | bus.out_ready;
  assign s0_adv       = ~s0_valid_q | s1_adv;
  assign s0_load      = bus.in_valid & s0_adv;
  assign s1_load      = s0_valid_q & s1_adv;
  assign bus.in_ready = s0_adv;

  // A coinciding event wins over clear, so clear only masks the held value.
  always_comb begin
    flag_nan_d  = (flag_nan_q & ~clear_flags_i) | (s1_load & s0_res.nan);
    flag_inf_d  = (flag_inf_q & ~clear_flags_i) | (s1_load & s0_res.inf);
    flag_ovf_d  = (flag_ovf_q & ~clear_flags_i) | (s1_load & s0_res.ovf);
    flag_unf_d  = (flag_unf_q & ~clear_flags_i) | (s1_load & s0_res.unf);
    nan_count_d = clear_flags_i ? '0 : nan_count_q;
    if (s1_load && s0_res.nan && (nan_count_d != {SizeCount{1'b1}})) begin
      nan_count_d = nan_count_d + SizeCount'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid_q  <= 1'b0;
      s0_number_q <= '0;
      s1_valid_q  <= 1'b0;
      s1_number_q <= '0;
      flag_nan_q  <= 1'b0;
      flag_inf_q  <= 1'b0;
      flag_ovf_q  <= 1'b0;
      flag_unf_q  <= 1'b0;
      nan_count_q <= '0;
    end else begin
      if (s0_adv)  s0_valid_q  <= bus.in_valid;
      if (s0_load) s0_number_q <= bus.in_number;
      if (s1_adv)  s1_valid_q  <= s0_valid_q;
      if (s1_load) s1_number_q <= s0_res.word;
      flag_nan_q  <= flag_nan_d;
      flag_inf_q  <= flag_inf_d;
      flag_ovf_q  <= flag_ovf_d;
      flag_unf_q  <= flag_unf_d;
      nan_count_q <= nan_count_d;
    end
  end

  assign bus.out_valid  = s1_valid_q;
  assign bus.out_number = s1_number_q;
  assign flag_nan_o     = flag_nan_q;
  assign flag_inf_o     = flag_inf_q;
  assign flag_ovf_o     = flag_ovf_q;
  assign flag_unf_o     = flag_unf_q;
  assign nan_count_o    = nan_count_q;

endmodule

// File: tb/tb_fp_ieee_packer.sv
// Self-checking bench for fp_ieee_packer: directed vectors, corner sequences, random traffic.
module tb_fp_ieee_packer;

  logic       clk;
  logic       rst;
  logic       clear_flags;
  logic       flag_nan, flag_inf, flag_ovf, flag_unf;
  logic [7:0] nan_count;

  fp_ieee_packer_if bus ();

  fp_ieee_packer dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .clear_flags_i (clear_flags),
    .flag_nan_o    (flag_nan),
    .flag_inf_o    (flag_inf),
    .flag_ovf_o    (flag_ovf),
    .flag_unf_o    (flag_unf),
    .nan_count_o   (nan_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [33:0] num;
    logic [31:0] out;
    logic [3:0]  flags;  // {nan, inf, ovf, unf}
    logic [7:0]  cnt;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference: IEEE encoding derived directly from the field values.
  function automatic logic [31:0] ref_pack(input logic [33:0] n);
    int unsigned exc = n[33:32];
    int unsigned e   = n[30:23];
    int unsigned f   = n[22:0];
    logic [31:0] sgn = n[31] ? 32'h8000_0000 : 32'h0;
    case (exc)
      0: return sgn;
      1: begin
        if (e == 255) return sgn | 32'h7F80_0000;
        if (e == 0) return sgn;
        return sgn | 32'(e * 32'h80_0000) | 32'(f);
      end
      2: return sgn | 32'h7F80_0000;
      default: return 32'h7FC0_0000;
    endcase
  endfunction

  // One clock: drive at negedge, sample 1ns later, score any handshakes before the next posedge.
  task automatic cyc(input logic iv, input logic [33:0] num, input logic ordy, input logic clr,
                     output logic acc, output logic got);
    logic [31:0] want;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_number = num;
    bus.out_ready = ordy;
    clear_flags   = clr;
    #1;
    acc = iv && bus.in_ready;
    got = bus.out_valid && ordy;
    if (acc) exp_q.push_back(ref_pack(num));
    if (got) begin
      if (exp_q.size() == 0) begin
        chk("spurious_output", {32'h0, bus.out_number}, 64'hDEAD);
      end else begin
        want = exp_q.pop_front();
        chk("out_number", {32'h0, bus.out_number}, {32'h0, want});
      end
    end
  endtask

  task automatic send_one(input logic [33:0] num, input logic [3:0] flags, input logic [7:0] cnt);
    logic acc, got;
    int   lat;
    cyc(1'b1, num, 1'b1, 1'b0, acc, got);
    chk("accept", {63'h0, acc}, 64'h1);
    lat = 0;
    got = 1'b0;
    for (int k = 1; k <= 8 && !got; k++) begin
      cyc(1'b0, 34'h0, 1'b1, 1'b0, acc, got);
      if (got) lat = k;
    end
    chk("latency", 64'(lat), 64'd2);
    chk("flags", {60'h0, flag_nan, flag_inf, flag_ovf, flag_unf}, {60'h0, flags});
    chk("nan_count", {56'h0, nan_count}, {56'h0, cnt});
  endtask

  function automatic logic [33:0] rand_num();
    logic [1:0]  exc = 2'($urandom_range(0, 3));
    logic        s   = 1'($urandom_range(0, 1));
    logic [7:0]  e;
    logic [22:0] f   = 23'($urandom);
    int unsigned r   = $urandom_range(0, 7);
    e = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
    return {exc, s, e, f};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[9];
    logic        acc, got, pend;
    logic [33:0] pnum;
    int          m_nan, m_inf, m_ovf, m_unf;

    vecs[0] = '{34'h1_3F80_0000, 32'h3F80_0000, 4'b0000, 8'd0};
    vecs[1] = '{34'h2_8000_0000, 32'hFF80_0000, 4'b0100, 8'd0};
    vecs[2] = '{34'h3_1234_5678, 32'h7FC0_0000, 4'b1000, 8'd1};
    vecs[3] = '{34'h0_8000_0000, 32'h8000_0000, 4'b0000, 8'd0};
    vecs[4] = '{34'h1_7F81_2345, 32'h7F80_0000, 4'b0010, 8'd0};
    vecs[5] = '{34'h1_0000_0005, 32'h0000_0000, 4'b0001, 8'd0};
    vecs[6] = '{34'h0_0000_0000, 32'h0000_0000, 4'b0000, 8'd0};
    vecs[7] = '{34'h1_C049_0FDB, 32'hC049_0FDB, 4'b0000, 8'd0};
    vecs[8] = '{34'h1_8000_0001, 32'h8000_0000, 4'b0001, 8'd0};

    rst = 1'b1;
    clear_flags = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_number = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
    chk("rst_out_number", {32'h0, bus.out_number}, 64'h0);
    chk("rst_in_ready", {63'h0, bus.in_ready}, 64'h1);
    chk("rst_flags", {60'h0, flag_nan, flag_inf, flag_ovf, flag_unf}, 64'h0);
    chk("rst_nan_count", {56'h0, nan_count}, 64'h0);

    foreach (vecs[i]) begin
      cyc(1'b0, 34'h0, 1'b1, 1'b1, acc, got);
      send_one(vecs[i].num, vecs[i].flags, vecs[i].cnt);
    end

    // Backpressure: A,B fill both stages, C is held until the consumer frees s1.
    cyc(1'b1, 34'h1_3F80_0000, 1'b0, 1'b0, acc, got);
    chk("bp_accept_a", {63'h0, acc}, 64'h1);
    cyc(1'b1, 34'h1_4000_0000, 1'b0, 1'b0, acc, got);
    chk("bp_accept_b", {63'h0, acc}, 64'h1);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, 34'h1_4040_0000, 1'b0, 1'b0, acc, got);
      chk("bp_in_ready_low", {63'h0, bus.in_ready}, 64'h0);
      chk("bp_hold_a", {32'h0, bus.out_number}, 64'h3F80_0000);
    end
    cyc(1'b1, 34'h1_4040_0000, 1'b1, 1'b0, acc, got);
    chk("bp_accept_c", {63'h0, acc}, 64'h1);
    chk("bp_emit_a", {63'h0, got}, 64'h1);
    cyc(1'b0, 34'h0, 1'b1, 1'b0, acc, got);
    chk("bp_emit_b", {63'h0, got}, 64'h1);
    cyc(1'b0, 34'h0, 1'b1, 1'b0, acc, got);
    chk("bp_emit_c", {63'h0, got}, 64'h1);
    cyc(1'b0, 34'h0, 1'b1, 1'b0, acc, got);
    chk("bp_drained", {63'h0, bus.out_valid}, 64'h0);

    // Saturation, then clear coinciding with a NaN entering s1.
    cyc(1'b0, 34'h0, 1'b1, 1'b1, acc, got);
    send_one(34'h2_0000_0000, 4'b0100, 8'd0);
    for (int k = 0; k < 300; k++) cyc(1'b1, 34'h3_0000_0001, 1'b1, 1'b0, acc, got);
    for (int k = 0; k < 3; k++) cyc(1'b0, 34'h0, 1'b1, 1'b0, acc, got);
    chk("sat_nan_count", {56'h0, nan_count}, 64'd255);
    chk("sat_flags", {60'h0, flag_nan, flag_inf, flag_ovf, flag_unf}, 64'b1100);
    cyc(1'b1, 34'h3_0000_0000, 1'b1, 1'b0, acc, got);
    cyc(1'b0, 34'h0, 1'b1, 1'b1, acc, got);
    cyc(1'b0, 34'h0, 1'b1, 1'b0, acc, got);
    chk("clr_nan_count", {56'h0, nan_count}, 64'd1);
    chk("clr_flags", {60'h0, flag_nan, flag_inf, flag_ovf, flag_unf}, 64'b1000);
    cyc(1'b0, 34'h0, 1'b1, 1'b0, acc, got);

    // Async reset with both stages full.
    cyc(1'b1, 34'h2_0000_0000, 1'b0, 1'b0, acc, got);
    cyc(1'b1, 34'h1_3F80_0000, 1'b0, 1'b0, acc, got);
    cyc(1'b0, 34'h0, 1'b0, 1'b0, acc, got);
    chk("ar_full", {62'h0, bus.out_valid, bus.in_ready}, 64'b10);
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", {63'h0, bus.out_valid}, 64'h0);
    chk("ar_flags", {60'h0, flag_nan, flag_inf, flag_ovf, flag_unf}, 64'h0);
    chk("ar_nan_count", {56'h0, nan_count}, 64'h0);
    rst = 1'b0;
    exp_q.delete();
    send_one(34'h1_3F80_0000, 4'b0000, 8'd0);

    // Random traffic with random backpressure against the reference model.
    cyc(1'b0, 34'h0, 1'b1, 1'b1, acc, got);
    m_nan = 0; m_inf = 0; m_ovf = 0; m_unf = 0;
    pend = 1'b0;
    pnum = '0;
    for (int i = 0; i < 600 || pend || exp_q.size() > 0; i++) begin
      if (i >= 640) begin
        chk("random_drain_timeout", 64'(exp_q.size()), 64'd0);
        break;
      end
      if (!pend && i < 600 && $urandom_range(0, 9) < 7) begin
        pnum = rand_num();
        pend = 1'b1;
      end
      cyc(pend, pnum, (i >= 600) || ($urandom_range(0, 9) < 6), 1'b0, acc, got);
      if (acc) begin
        pend = 1'b0;
        if (pnum[33:32] == 2'd3) m_nan++;
        if (pnum[33:32] == 2'd2) m_inf++;
        if (pnum[33:32] == 2'd1 && pnum[30:23] == 8'hFF) m_ovf++;
        if (pnum[33:32] == 2'd1 && pnum[30:23] == 8'h00) m_unf++;
      end
    end
    cyc(1'b0, 34'h0, 1'b1, 1'b0, acc, got);
    chk("rnd_empty", {63'h0, bus.out_valid}, 64'h0);
    chk("rnd_flags", {60'h0, flag_nan, flag_inf, flag_ovf, flag_unf},
        {60'h0, m_nan > 0, m_inf > 0, m_ovf > 0, m_unf > 0});
    chk("rnd_nan_count", {56'h0, nan_count}, 64'((m_nan > 255) ? 255 : m_nan));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
